// File: rtl/regseq_pkg.sv
// Shared types and defaults for the register-file sequencer and its ALU.
// Opcode and FSM state encodings live here so every file agrees on them.
package regseq_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 3;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      OR  = 3'b011,
      XOR = 3'b100,
      MOV = 3'b101,
      LDI = 3'b110,
      CMP = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      EXEC = 2'd2
   } state_e;

   // CMP is the only opcode that updates flags without writing the file.
   function automatic logic op_writes(input op_e op);
      return op != CMP;
   endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction handshake, register-file bus and result reporting bundled together.
// master = sequencer side, slave = controller/register-file side.
interface regfile_sequencer_if #(
   parameter int DW = 8,
   parameter int AW = 3
);

   logic          instr_valid;
   logic          instr_ready;
   logic [2:0]    op;
   logic [AW-1:0] src1;
   logic [AW-1:0] src2;
   logic [AW-1:0] dst;
   logic [DW-1:0] imm;

   logic [AW-1:0] rf_a1;
   logic [AW-1:0] rf_a2;
   logic [AW-1:0] rf_a3;
   logic          rf_we;
   logic [DW-1:0] rf_wd;
   logic [DW-1:0] rf_rd1;
   logic [DW-1:0] rf_rd2;

   logic [DW-1:0] result;
   logic          result_valid;
   logic          flag_z;
   logic          flag_c;

   modport master (
      input  instr_valid, op, src1, src2, dst, imm, rf_rd1, rf_rd2,
      output instr_ready, rf_a1, rf_a2, rf_a3, rf_we, rf_wd,
             result, result_valid, flag_z, flag_c
   );

   modport slave (
      output instr_valid, op, src1, src2, dst, imm, rf_rd1, rf_rd2,
      input  instr_ready, rf_a1, rf_a2, rf_a3, rf_we, rf_wd,
             result, result_valid, flag_z, flag_c
   );

endinterface

// File: rtl/regseq_alu.sv
// Combinational 8-op ALU for the sequencer: result plus carry/borrow.
// Carry is the ADD carry-out, or the SUB/CMP borrow; zero for every other op.
module regseq_alu
   import regseq_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  op_e           op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic [DW-1:0] imm_i,
   output logic [DW-1:0] y_o,
   output logic          c_o
);

   logic [DW:0] sum;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      sum = {1'b0, a_i} + {1'b0, b_i};
      y_o = '0;
      c_o = 1'b0;
      case (op_i)
         ADD: begin
            y_o = sum[DW-1:0];
            c_o = sum[DW];
         end
         SUB, CMP: begin
            y_o = a_i - b_i;
            c_o = a_i < b_i;
         end
         AND: y_o = a_i & b_i;
         OR:  y_o = a_i | b_i;
         XOR: y_o = a_i ^ b_i;
         MOV: y_o = a_i;
         LDI: y_o = imm_i;
      endcase
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequencer: accepts one instruction, reads two registers, runs the ALU and writes back.
// Three-cycle IDLE -> ADDR -> EXEC loop; result and flags register at the end of EXEC.
module regfile_sequencer
   import regseq_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input logic                 clk,
   input logic                 rst,
   regfile_sequencer_if.master seq_if
);

   state_e        state_q, state_d;
   op_e           op_q, op_d;
   logic [AW-1:0] rf_a1_q, rf_a1_d;
   logic [AW-1:0] rf_a2_q, rf_a2_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [DW-1:0] imm_q, imm_d;
   logic [DW-1:0] result_q, result_d;
   logic          result_valid_q, result_valid_d;
   logic          flag_z_q, flag_z_d;
   logic          flag_c_q, flag_c_d;

   logic [DW-1:0] alu_y;
   logic          alu_c;
   logic          instr_ready;

   regseq_alu #(.DW(DW)) u_alu (
      .op_i  (op_q),
      .a_i   (seq_if.rf_rd1),
      .b_i   (seq_if.rf_rd2),
      .imm_i (imm_q),
      .y_o   (alu_y),
      .c_o   (alu_c)
   );

   // Ready is gated by rst so it reads 0 for the whole reset window, not just after an edge.
   assign instr_ready = (state_q == IDLE) && !rst;

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      rf_a1_d        = rf_a1_q;
      rf_a2_d        = rf_a2_q;
      dst_d          = dst_q;
      imm_d          = imm_q;
      result_d       = result_q;
      flag_z_d       = flag_z_q;
      flag_c_d       = flag_c_q;
      result_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (seq_if.instr_valid && instr_ready) begin
               op_d    = op_e'(seq_if.op);
               rf_a1_d = seq_if.src1;
               rf_a2_d = seq_if.src2;
               dst_d   = seq_if.dst;
               imm_d   = seq_if.imm;
               state_d = ADDR;
            end
         end
         ADDR: state_d = EXEC;
         EXEC: begin
            result_d       = alu_y;
            flag_z_d       = (alu_y == '0);
            flag_c_d       = alu_c;
            result_valid_d = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         op_q           <= ADD;
         rf_a1_q        <= '0;
         rf_a2_q        <= '0;
         dst_q          <= '0;
         imm_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         flag_z_q       <= 1'b0;
         flag_c_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         rf_a1_q        <= rf_a1_d;
         rf_a2_q        <= rf_a2_d;
         dst_q          <= dst_d;
         imm_q          <= imm_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         flag_z_q       <= flag_z_d;
         flag_c_q       <= flag_c_d;
      end
   end

   // Write enable is decoded from state so an async reset kills it immediately.
   assign seq_if.rf_we        = (state_q == EXEC) && op_writes(op_q);
   assign seq_if.rf_a1        = rf_a1_q;
   assign seq_if.rf_a2        = rf_a2_q;
   assign seq_if.rf_a3        = dst_q;
   assign seq_if.rf_wd        = alu_y;
   assign seq_if.instr_ready  = instr_ready;
   assign seq_if.result       = result_q;
   assign seq_if.result_valid = result_valid_q;
   assign seq_if.flag_z       = flag_z_q;
   assign seq_if.flag_c       = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer with a behavioural register file and an arithmetic reference model.
module tb_regfile_sequencer;

   localparam int DW = 8;
   localparam int AW = 3;

   localparam int C_ADD = 0;
   localparam int C_SUB = 1;
   localparam int C_AND = 2;
   localparam int C_OR  = 3;
   localparam int C_XOR = 4;
   localparam int C_MOV = 5;
   localparam int C_LDI = 6;
   localparam int C_CMP = 7;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   logic [DW-1:0] rf_mem [8];
   int            ref_mem [8];

   regfile_sequencer_if #(.DW(DW), .AW(AW)) bus ();

   regfile_sequencer #(.DW(DW), .AW(AW)) dut (
      .clk    (clk),
      .rst    (rst),
      .seq_if (bus.master)
   );

   always #5 clk = ~clk;

   // Register file: one write port, two registered read ports (old data on a same-edge write).
   always @(posedge clk) begin
      if (bus.rf_we) rf_mem[bus.rf_a3] <= bus.rf_wd;
      bus.rf_rd1 <= rf_mem[bus.rf_a1];
      bus.rf_rd2 <= rf_mem[bus.rf_a2];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model(input int op, input int a, input int b, input int imm,
                                 output int y, output bit c, output bit z);
      y = 0;
      c = 1'b0;
      case (op)
         C_ADD: begin
            y = a + b;
            c = (y > 255);
            y = y % 256;
         end
         C_SUB, C_CMP: begin
            c = (a < b);
            y = (a - b + 256) % 256;
         end
         C_AND: y = a & b;
         C_OR:  y = a | b;
         C_XOR: y = a ^ b;
         C_MOV: y = a;
         C_LDI: y = imm;
         default: y = 0;
      endcase
      z = (y == 0);
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      while (bus.instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (bus.instr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s ready_timeout: instr_ready=%b required 1", name, bus.instr_ready);
      end
   endtask

   task automatic drive_instr(input int op, input int s1, input int s2, input int d, input int imm);
      bus.op          = 3'(op);
      bus.src1        = 3'(s1);
      bus.src2        = 3'(s2);
      bus.dst         = 3'(d);
      bus.imm         = 8'(imm);
      bus.instr_valid = 1'b1;
   endtask

   // Runs one instruction from an IDLE negedge and checks ADDR, EXEC and the result cycle.
   task automatic run_instr(input string name, input int op, input int s1, input int s2,
                            input int d, input int imm);
      int y;
      bit c, z;
      wait_ready(name);
      model(op, ref_mem[s1], ref_mem[s2], imm, y, c, z);
      drive_instr(op, s1, s2, d, imm);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.op   = 3'($urandom);
      bus.src1 = 3'($urandom);
      bus.src2 = 3'($urandom);
      bus.dst  = 3'($urandom);
      bus.imm  = 8'($urandom);
      tests_run++;
      if (bus.rf_a1 !== 3'(s1) || bus.rf_a2 !== 3'(s2)) begin
         tests_failed++;
         $display("FAIL %s addr: a1=%0d a2=%0d required %0d %0d", name, bus.rf_a1, bus.rf_a2, s1, s2);
      end
      tests_run++;
      if ({bus.instr_ready, bus.rf_we, bus.result_valid} !== 3'b000) begin
         tests_failed++;
         $display("FAIL %s addr_ctrl: ready/we/rv=%b required 000", name,
                  {bus.instr_ready, bus.rf_we, bus.result_valid});
      end
      @(negedge clk);
      tests_run++;
      if (bus.rf_we !== (op != C_CMP) || bus.rf_wd !== 8'(y)) begin
         tests_failed++;
         $display("FAIL %s exec: we=%b wd=%02h required we=%b wd=%02h", name, bus.rf_we, bus.rf_wd,
                  (op != C_CMP), 8'(y));
      end
      if (op != C_CMP) begin
         tests_run++;
         if (bus.rf_a3 !== 3'(d)) begin
            tests_failed++;
            $display("FAIL %s exec_a3: a3=%0d required %0d", name, bus.rf_a3, d);
         end
         ref_mem[d] = y;
      end
      tests_run++;
      if ({bus.instr_ready, bus.result_valid} !== 2'b00) begin
         tests_failed++;
         $display("FAIL %s exec_ctrl: ready/rv=%b required 00", name, {bus.instr_ready, bus.result_valid});
      end
      @(negedge clk);
      tests_run++;
      if (bus.result_valid !== 1'b1 || bus.result !== 8'(y) || bus.flag_z !== z || bus.flag_c !== c) begin
         tests_failed++;
         $display("FAIL %s result: rv=%b res=%02h z=%b c=%b required rv=1 res=%02h z=%b c=%b", name,
                  bus.result_valid, bus.result, bus.flag_z, bus.flag_c, 8'(y), z, c);
      end
   endtask

   task automatic check_all_zero(input string name);
      tests_run++;
      if ({bus.instr_ready, bus.rf_we, bus.rf_a1, bus.rf_a2, bus.rf_a3, bus.result,
           bus.result_valid, bus.flag_z, bus.flag_c} !== '0) begin
         tests_failed++;
         $display("FAIL %s: ready=%b we=%b a1=%0d a2=%0d a3=%0d res=%02h rv=%b z=%b c=%b required all 0",
                  name, bus.instr_ready, bus.rf_we, bus.rf_a1, bus.rf_a2, bus.rf_a3, bus.result,
                  bus.result_valid, bus.flag_z, bus.flag_c);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.instr_valid = 1'b0;
      drive_instr(0, 0, 0, 0, 0);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      check_all_zero("reset_held");
      @(negedge clk);
      check_all_zero("reset_held_2");
      rst = 1'b0;
      #1;
      tests_run++;
      if (bus.instr_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: instr_ready=%b required 1", bus.instr_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_add;
      run_instr("add_r3", C_ADD, 0, 1, 3, 0);
      tests_run++;
      if (bus.result !== 8'h03) begin
         tests_failed++;
         $display("FAIL add_r3_const: result=%02h required 03", bus.result);
      end
   endtask

   task automatic test_ldi_add;
      run_instr("ldi_r2", C_LDI, 0, 0, 2, 8'hFF);
      run_instr("add_r4_wrap", C_ADD, 2, 0, 4, 0);
      run_instr("mov_r5", C_MOV, 4, 0, 5, 0);
   endtask

   task automatic test_sub_cmp;
      run_instr("sub_r6", C_SUB, 0, 1, 6, 0);
      run_instr("cmp_r3", C_CMP, 3, 3, 0, 0);
   endtask

   task automatic test_back_to_back;
      int expv;
      wait_ready("b2b");
      expv = ref_mem[0];
      drive_instr(C_ADD, 0, 0, 0, 0);
      for (int k = 0; k <= 6; k++) begin
         tests_run++;
         if (bus.instr_ready !== ((k % 3) == 0)) begin
            tests_failed++;
            $display("FAIL b2b_ready[%0d]: instr_ready=%b required %b", k, bus.instr_ready, ((k % 3) == 0));
         end
         if (k == 3 || k == 6) begin
            expv = (expv * 2) % 256;
            tests_run++;
            if (bus.result_valid !== 1'b1 || bus.result !== 8'(expv)) begin
               tests_failed++;
               $display("FAIL b2b_result[%0d]: rv=%b res=%02h required rv=1 res=%02h", k,
                        bus.result_valid, bus.result, 8'(expv));
            end
         end
         if (k < 6) @(negedge clk);
      end
      bus.instr_valid = 1'b0;
      ref_mem[0] = expv;
   endtask

   task automatic test_reset_abort;
      wait_ready("abort");
      drive_instr(C_LDI, 0, 0, 1, 8'hAA);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.rf_we !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_we_before: rf_we=%b required 1", bus.rf_we);
      end
      #2 rst = 1'b1;
      #1;
      check_all_zero("abort_async");
      @(negedge clk);
      check_all_zero("abort_held");
      rst = 1'b0;
      #1;
      run_instr("abort_mov_r2", C_MOV, 1, 0, 2, 0);
      tests_run++;
      if (bus.result !== 8'h02) begin
         tests_failed++;
         $display("FAIL abort_readback: result=%02h required 02", bus.result);
      end
   endtask

   task automatic test_field_change;
      run_instr("field_xor", C_XOR, 3, 6, 7, 0);
      run_instr("field_and", C_AND, 7, 5, 1, 0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         run_instr($sformatf("rand%0d", i), int'($urandom_range(7)), int'($urandom_range(7)),
                   int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(255)));
      end
   endtask

   initial begin
      for (int i = 0; i < 7; i++) begin
         rf_mem[i]  = 8'(i + 1);
         ref_mem[i] = i + 1;
      end
      rf_mem[7]  = 8'($urandom);
      ref_mem[7] = int'(rf_mem[7]);
      test_reset();
      test_add();
      test_ldi_add();
      test_sub_cmp();
      test_back_to_back();
      test_reset_abort();
      test_field_change();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Initiator for the 8-entry x 8-bit register file (RegisterFile). It has two synchronous read ports, one write port, and a 1-cycle registered read.
- Accepts one instruction over a valid/ready handshake and drives the file's read addresses.
- Consumes rd1/rd2 one cycle later, computes an 8-bit ALU result and writes it back.
- Reports the result and the flags to the upstream controller.

Parameters:
- DW, 8, data width; must match the register file.
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction fields are valid.
- instr_ready  out  1  sequencer can accept an instruction.
- op  in  3  opcode (see Behaviour).
- src1  in  AW  first source register.
- src2  in  AW  second source register.
- dst  in  AW  destination register.
- imm  in  DW  immediate, used by LDI only.
- rf_a1  out  AW  register file read address 1.
- rf_a2  out  AW  register file read address 2.
- rf_a3  out  AW  register file write address.
- rf_we  out  1  register file write enable.
- rf_wd  out  DW  register file write data.
- rf_rd1  in  DW  read data 1; valid one cycle after rf_a1 is presented.
- rf_rd2  in  DW  read data 2; valid one cycle after rf_a2 is presented.
- result  out  DW  last computed result.
- result_valid  out  1  one-cycle pulse when result/flags update.
- flag_z  out  1  last result equal to zero.
- flag_c  out  1  ADD carry-out / SUB,CMP borrow.

Behaviour:
- Reset is asynchronous. While rst is high: state=IDLE, instr_ready=0, rf_we=0, rf_a1/a2/a3=0, result=0, result_valid=0, flag_z=0, flag_c=0.
- A reset in the middle of an instruction aborts it, with no write. rf_we drops immediately because it is decoded from state.
- FSM states: IDLE -> ADDR -> EXEC -> IDLE. There are no other states; any illegal state encoding goes to IDLE.
- IDLE:
  - instr_ready=1.
  - On valid&ready, latch op/src1/src2/dst/imm, register rf_a1=src1 and rf_a2=src2, and go to ADDR.
  - While instr_valid is low, remain in IDLE.
- ADDR:
  - instr_ready=0.
  - Addresses are held stable; the register file captures read data at the end of this cycle.
- EXEC:
  - instr_ready=0.
  - ALU result is computed combinationally from rf_rd1/rf_rd2/imm.
  - rf_a3=dst; rf_wd=ALU result.
  - rf_we=1 for every op except CMP.
  - At the end of the cycle: result, flag_z and flag_c are registered and result_valid is set for exactly the next cycle; state returns to IDLE.
- Latency and throughput:
  - Accept edge E0; write commits at E0+2; result_valid is high during the cycle after E0+2.
  - Throughput is 1 instruction per 3 cycles.
  - A back-to-back instruction reading the previous dst sees the new value; no forwarding is needed.
- Opcodes:
  - 000 ADD: rd1+rd2; c=bit 8 of the 9-bit sum.
  - 001 SUB: rd1-rd2 modulo 256; c=(rd1<rd2).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MOV: rd1.
  - 110 LDI: imm. Still passes through ADDR/EXEC for uniform latency.
  - 111 CMP: same as SUB but no write; result and flags still update.
- Flag rules:
  - Logic ops, MOV and LDI set c=0.
  - z=(result==0) for all ops.
- src1==src2 is legal, and dst==src is legal. The read occurs in ADDR, before the write edge, so the old value is used.
- instr fields are sampled only on the accept edge; changes while busy are ignored.
- result and flags hold their values between instructions.

Decomposition:
- Package regseq_pkg:
  - op_e enum: ADD, SUB, AND, OR, XOR, MOV, LDI, CMP.
  - state_e enum: IDLE, ADDR, EXEC.
  - DW/AW default constants.
- Sub-module regseq_alu (combinational): inputs op, a, b, imm; outputs y[DW-1:0], c.
- The sequencer instantiates regseq_alu. The bench instantiates the sequencer plus RegisterFile. The register file powers up with r0..r6 = 1..7; r7 is undefined.

Test Plan:
- Reset, then ADD dst=r3 src1=r0 src2=r1 -> rf_we=1 in EXEC with rf_a3=3, rf_wd=0x03; result_valid pulse; result=0x03, z=0, c=0; accept-to-valid is 3 edges.
- LDI r2=0xFF, then ADD r4=r2+r0 -> result=0x00, z=1, c=1; r4 readback via MOV r5=r4 gives 0x00.
- SUB r6=r0-r1 (1-2) -> 0xFF, c=1, z=0. CMP r3,r3 -> z=1, c=0, and rf_we stays 0 for the whole instruction.
- Back-to-back with instr_valid held high: ADD r0=r0+r0, then ADD r0=r0+r0 -> r0 goes 1->2->4; instr_ready is high exactly once every 3 cycles.
- Assert rst during EXEC of LDI r1=0xAA -> rf_we falls without a clock edge; after release, MOV r2=r1 returns 0x02 (write aborted); all outputs are zero during reset.
- Change op/src fields during ADDR/EXEC -> no effect on the in-flight instruction's rf_a1/rf_a2/rf_wd.
